bp_me_cce_burst_monitor: RTL
============================

// Module: bp_me_cce_burst_monitor
// PURPOSE
//   Passive, synthesizable multi-channel monitor for the BedRock burst (ready&valid) links at the CCE:
//   LCE req/resp/cmd and mem cmd/resp. Per channel it taps header and data handshakes and tracks
//   burst state. It counts headers and data beats, flags protocol violations and stalls, and exposes
//   the results as registered status. Generalised in channel count, burst length and limits.
// PARAMETERS
//   num_ch_p       6     number of monitored channels
//   max_beats_p    8     max data beats per message (>=1); bw = clog2(max_beats_p+1)
//   stall_limit_p  1024  consecutive v&~ready cycles before a stall error (>=2)
//   cnt_width_p    32    width of each per-channel counter
// PORTS
//   clk_i             in   1                    clock
//   reset_n_i         in   1                    async active-low reset
//   clear_i           in   1                    sync clear: counters, sticky errors, stall timers
//   hdr_v_i           in   num_ch_p             header valid
//   hdr_ready_and_i   in   num_ch_p             header ready
//   hdr_beats_i       in   num_ch_p*bw          data beats following this header (0 = header-only)
//   data_v_i          in   num_ch_p             data beat valid
//   data_ready_and_i  in   num_ch_p             data beat ready
//   busy_o            out  num_ch_p             channel in DATA state (beats outstanding)
//   err_o             out  num_ch_p             sticky error flag
//   err_code_o        out  num_ch_p*3           first error code since reset/clear
//   stall_o           out  num_ch_p             hdr or data stall timer at limit
//   hdr_count_o       out  num_ch_p*cnt_width_p header handshakes, saturating
//   beat_count_o      out  num_ch_p*cnt_width_p data handshakes, saturating
// BEHAVIOUR
// - Async reset: all outputs 0, FSMs IDLE, rem=0, timers 0, prev-valid regs 0.
// - hs = v & ready at posedge. All outputs registered; they reflect an event 1 cycle later.
// - FSM per channel, rem = beats remaining:
//     IDLE: hdr hs, beats=b>0 -> DATA, rem=b. If data hs in the same cycle, it is the first beat:
//       rem=b-1, and the FSM stays IDLE if b==1. hdr hs with b=0 -> IDLE.
//     DATA: data hs -> rem-1; at rem==1 -> IDLE. A hdr hs in that same final-beat cycle is legal
//       and loads the new burst.
// - Error codes (3b):
//     1 DATA_IN_IDLE   data hs with no burst open
//     2 HDR_IN_DATA    hdr hs in DATA, not on the final beat
//     3 BEATS_OOR      hdr_beats_i > max_beats_p
//     4 HDR_V_DROP     hdr_v high & not ready last cycle, low now
//     5 DATA_V_DROP    same check for data
//     6 STALL
// - Error recovery:
//     code 1: beat still counted; FSM stays IDLE.
//     code 2: new header replaces the burst (rem=new beats).
//     code 3: rem clamps to max_beats_p.
// - err_o is sticky. err_code_o latches only the first error; if errors are simultaneous, the
//   lowest code wins. Later errors leave the code unchanged.
// - Stall: separate hdr and data timers per channel. The timer increments on v&~ready and resets
//   to 0 on hs or ~v. It saturates at stall_limit_p. At limit: stall_o=1 and code 6 is raised once.
//   stall_o drops the cycle after the hs (or after v drops).
// - Counters +1 per hs and saturate at all-ones; they never wrap.
// - clear_i wins over same-cycle increments and errors. FSM state and rem are preserved, so a
//   mid-burst clear does not desync.
// - Reset asserted mid-burst: immediate return to IDLE; the following beats after reset raise code 1.
// TESTING
//   T1 ch0: hdr hs beats=4, then 4 data hs -> busy_o[0] high 4 cycles; hdr_count=1, beat_count=4;
//      err_o=0.
//   T2 ch1: hdr hs beats=2 + data hs same cycle, 1 more beat -> IDLE after 2nd beat; no error.
//   T3 ch2: hdr beats=3, 1 beat, then 2nd hdr hs -> err_code=2; rem reloads; later code 1 does
//      not overwrite.
//   T4 ch3: hdr_v=1, ready=0 for stall_limit_p cycles -> stall_o[3]=1 and code 6; ready=1 ->
//      stall_o clears next cycle.
//   T5 ch4: data hs in IDLE and hdr_beats=9 (max 8) in the same cycle -> code 1 (lowest), rem=8.
//   T6: counters preloaded at all-ones -> hs holds them at saturation. clear_i mid-burst ->
//      counters/err 0, busy_o stays 1, burst completes cleanly.

Source files
------------

// File: rtl/bp_me_cce_burst_monitor_if.sv
// Tap and status bundle for the CCE burst monitor: per-channel header/data
// handshake taps in, per-channel burst status out.
interface bp_me_cce_burst_monitor_if #(
    parameter int unsigned num_ch_p    = 6,
    parameter int unsigned bw_p        = 4,
    parameter int unsigned cnt_width_p = 32
);
    logic [num_ch_p-1:0]             hdr_v_i;
    logic [num_ch_p-1:0]             hdr_ready_and_i;
    logic [num_ch_p*bw_p-1:0]        hdr_beats_i;
    logic [num_ch_p-1:0]             data_v_i;
    logic [num_ch_p-1:0]             data_ready_and_i;

    logic [num_ch_p-1:0]             busy_o;
    logic [num_ch_p-1:0]             err_o;
    logic [num_ch_p*3-1:0]           err_code_o;
    logic [num_ch_p-1:0]             stall_o;
    logic [num_ch_p*cnt_width_p-1:0] hdr_count_o;
    logic [num_ch_p*cnt_width_p-1:0] beat_count_o;

    modport master (
        output hdr_v_i, hdr_ready_and_i, hdr_beats_i, data_v_i, data_ready_and_i,
        input  busy_o, err_o, err_code_o, stall_o, hdr_count_o, beat_count_o
    );

    modport slave (
        input  hdr_v_i, hdr_ready_and_i, hdr_beats_i, data_v_i, data_ready_and_i,
        output busy_o, err_o, err_code_o, stall_o, hdr_count_o, beat_count_o
    );
endinterface

// File: rtl/bp_me_cce_burst_monitor.sv
// Passive multi-channel BedRock burst monitor: tracks header/data bursts per
// channel, counts handshakes, and latches the first protocol or stall error.
module bp_me_cce_burst_monitor #(
    parameter int unsigned num_ch_p      = 6,
    parameter int unsigned max_beats_p   = 8,
    parameter int unsigned stall_limit_p = 1024,
    parameter int unsigned cnt_width_p   = 32
) (
    input  logic                        clk_i,
    input  logic                        reset_n_i,
    input  logic                        clear_i,
    bp_me_cce_burst_monitor_if.slave    mon
);
    localparam int unsigned bw = $clog2(max_beats_p + 1);
    localparam int unsigned tw = $clog2(stall_limit_p + 1);
    localparam logic [bw-1:0] max_beats_lp = bw'(max_beats_p);
    localparam logic [tw-1:0] limit_lp     = tw'(stall_limit_p);

    typedef enum logic {
        IDLE = 1'b0,
        DATA = 1'b1
    } state_e;

    logic [num_ch_p-1:0]                  busy;
    logic [num_ch_p-1:0]                  err;
    logic [num_ch_p-1:0]                  stall;
    logic [num_ch_p-1:0][2:0]             code;
    logic [num_ch_p-1:0][cnt_width_p-1:0] hdr_cnt;
    logic [num_ch_p-1:0][cnt_width_p-1:0] beat_cnt;

    for (genvar ch = 0; ch < num_ch_p; ch++) begin : g_ch
        state_e                 state_q, state_n;
        logic [bw-1:0]          rem_q, rem_n;
        logic [bw-1:0]          beats_raw, beats_eff;
        logic                   beats_oor;
        logic                   hdr_hs, data_hs, final_beat;
        logic                   hdr_wait, data_wait;
        logic [tw-1:0]          hdr_tmr_q, hdr_tmr_n, data_tmr_q, data_tmr_n;
        logic                   hdr_pend_q, data_pend_q;
        logic [6:1]             evt;
        logic [2:0]             evt_code;
        logic                   err_q, stall_q;
        logic [2:0]             code_q;
        logic [cnt_width_p-1:0] hdr_cnt_q, beat_cnt_q;

        assign hdr_hs     = mon.hdr_v_i[ch] & mon.hdr_ready_and_i[ch];
        assign data_hs    = mon.data_v_i[ch] & mon.data_ready_and_i[ch];
        assign hdr_wait   = mon.hdr_v_i[ch] & ~mon.hdr_ready_and_i[ch];
        assign data_wait  = mon.data_v_i[ch] & ~mon.data_ready_and_i[ch];
        assign beats_raw  = mon.hdr_beats_i[ch*bw +: bw];
        assign beats_oor  = (beats_raw > max_beats_lp);
        assign beats_eff  = beats_oor ? max_beats_lp : beats_raw;
        assign final_beat = data_hs && (rem_q == bw'(1));

        // Burst FSM, stall timers and error event detection
        always_comb begin
            state_n    = state_q;
            rem_n      = rem_q;
            hdr_tmr_n  = '0;
            data_tmr_n = '0;
            evt        = '0;
            evt_code   = 3'd0;

            if (hdr_wait)
                hdr_tmr_n = (hdr_tmr_q == limit_lp) ? hdr_tmr_q : hdr_tmr_q + tw'(1);
            if (data_wait)
                data_tmr_n = (data_tmr_q == limit_lp) ? data_tmr_q : data_tmr_q + tw'(1);

            evt[3] = hdr_hs & beats_oor;
            evt[4] = hdr_pend_q & ~mon.hdr_v_i[ch];
            evt[5] = data_pend_q & ~mon.data_v_i[ch];
            evt[6] = ((hdr_tmr_n == limit_lp) && (hdr_tmr_q != limit_lp)) ||
                     ((data_tmr_n == limit_lp) && (data_tmr_q != limit_lp));

            case (state_q)
                IDLE: begin
                    if (hdr_hs && (beats_eff != '0)) begin
                        // A malformed (clamped) header cannot claim the concurrent beat
                        if (data_hs && !beats_oor) begin
                            rem_n   = beats_eff - bw'(1);
                            state_n = (beats_eff == bw'(1)) ? IDLE : DATA;
                        end else begin
                            rem_n   = beats_eff;
                            state_n = DATA;
                            evt[1]  = data_hs;
                        end
                    end else begin
                        evt[1] = data_hs;
                    end
                end
                DATA: begin
                    if (hdr_hs) begin
                        evt[2]  = ~final_beat;
                        rem_n   = beats_eff;
                        state_n = (beats_eff == '0) ? IDLE : DATA;
                    end else if (data_hs) begin
                        rem_n   = rem_q - bw'(1);
                        state_n = (rem_q == bw'(1)) ? IDLE : DATA;
                    end
                end
                default: begin
                    state_n = IDLE;
                    rem_n   = '0;
                end
            endcase

            for (int k = 6; k >= 1; k--)
                if (evt[k]) evt_code = 3'(k);
        end

        // Burst state is never cleared so a mid-burst clear stays in sync
        always_ff @(posedge clk_i or negedge reset_n_i) begin
            if (!reset_n_i) begin
                state_q     <= IDLE;
                rem_q       <= '0;
                hdr_pend_q  <= 1'b0;
                data_pend_q <= 1'b0;
                hdr_tmr_q   <= '0;
                data_tmr_q  <= '0;
                err_q       <= 1'b0;
                code_q      <= 3'd0;
                stall_q     <= 1'b0;
                hdr_cnt_q   <= '0;
                beat_cnt_q  <= '0;
            end else begin
                state_q     <= state_n;
                rem_q       <= rem_n;
                hdr_pend_q  <= hdr_wait;
                data_pend_q <= data_wait;
                if (clear_i) begin
                    hdr_tmr_q  <= '0;
                    data_tmr_q <= '0;
                    err_q      <= 1'b0;
                    code_q     <= 3'd0;
                    stall_q    <= 1'b0;
                    hdr_cnt_q  <= '0;
                    beat_cnt_q <= '0;
                end else begin
                    hdr_tmr_q  <= hdr_tmr_n;
                    data_tmr_q <= data_tmr_n;
                    stall_q    <= (hdr_tmr_n == limit_lp) || (data_tmr_n == limit_lp);
                    if (!err_q && (evt != '0)) begin
                        err_q  <= 1'b1;
                        code_q <= evt_code;
                    end
                    if (hdr_hs && (hdr_cnt_q != '1))
                        hdr_cnt_q <= hdr_cnt_q + cnt_width_p'(1);
                    if (data_hs && (beat_cnt_q != '1))
                        beat_cnt_q <= beat_cnt_q + cnt_width_p'(1);
                end
            end
        end

        assign busy[ch]     = (state_q == DATA);
        assign err[ch]      = err_q;
        assign code[ch]     = code_q;
        assign stall[ch]    = stall_q;
        assign hdr_cnt[ch]  = hdr_cnt_q;
        assign beat_cnt[ch] = beat_cnt_q;
    end

    assign mon.busy_o       = busy;
    assign mon.err_o        = err;
    assign mon.err_code_o   = code;
    assign mon.stall_o      = stall;
    assign mon.hdr_count_o  = hdr_cnt;
    assign mon.beat_count_o = beat_cnt;
endmodule
